muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the Execute stage. It is the stall-requesting end of the hazard interface:
//  it raises stall_req_o while an M-extension op is in flight and honours flush_i from the hazard unit.
//  The hazard unit ORs stall_req_o into stall_f/stall_d/stall_e, freezing the M-op in EX until result_valid_o.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk             in   1     core clock, rising edge
//  rst_n           in   1     async active-low reset
//  start_i         in   1     EX holds a valid M-op (level; held high while stalled)
//  op_i            in   3     funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU (0..7)
//  a_i             in   XLEN  rs1 operand (post-forwarding)
//  b_i             in   XLEN  rs2 operand (post-forwarding)
//  rd_addr_i       in   5     destination tag, captured on accept
//  flush_i         in   1     flush_e from hazard unit; aborts op
//  stall_req_o     out  1     stall request to hazard unit (comb)
//  result_valid_o  out  1     one-cycle pulse, result_o/rd_addr_o valid
//  result_o        out  XLEN  result
//  rd_addr_o       out  5     captured tag
// BEHAVIOUR
//  Reset: state=IDLE; result_o=0, rd_addr_o=0, result_valid_o=0; stall_req_o forced 0 while rst_n low.
//  States: IDLE, MUL, DIV, FIX, DONE.
//  IDLE: accept when start_i && !flush_i: latch op, |a|,|b|, sign flags, rd; count=0.
//    DIV/DIVU/REM/REMU with b==0 -> DONE, quotient=all-ones, remainder=a.
//    DIV/REM with a==0x8000_0000 && b==all-ones -> DONE, quotient=a, remainder=0.
//    Otherwise MUL or DIV.
//  MUL: shift-add on 2*XLEN product, 1 bit/cycle; after XLEN cycles -> FIX.
//  DIV: restoring, 1 quotient bit/cycle; after XLEN cycles -> FIX.
//  FIX: sign correction. MULH: both signed. MULHSU: a signed only. Quotient negated if signs differ.
//    Remainder takes dividend sign. Select low/high/quot/rem; -> DONE.
//  DONE: result_valid_o=1 for exactly this cycle; -> IDLE. start_i ignored here (same stalled instr).
//  Latency: valid exactly XLEN+2 cycles after accept cycle (34 @32); special cases: 1 cycle.
//  stall_req_o = (IDLE && start_i && !flush_i) || state in {MUL,DIV,FIX}; 0 in DONE so pipeline advances.
//  flush_i: any state -> IDLE next edge, no result_valid_o; flush in accept cycle suppresses accept; flush beats start.
//  start_i while not IDLE: ignored (no restart, operands not re-sampled).
//  Reset mid-operation: immediate return to reset values; no valid pulse.
//  Counter width $clog2(XLEN)+1; no overflow. All arithmetic unsigned on magnitudes, 2*XLEN internal.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined: MUL* ops computed by single-cycle 2*XLEN multiplier; IDLE->DONE, valid 1 cycle after accept.
//    Divides unchanged.
//  Not defined: all MUL* iterative as above; no multiplier inferred.
// STRUCTURE
//  common/pipeline_types.svh: mdu_op_t enum (funct3 encodings), mdu_state_t enum, MDU_OP_WIDTH=3.
//  Sub-module mdu_div_core: restoring divider datapath (remainder/quotient shift regs + step enable).
//    FSM, multiplier, fix-up stay in muldiv_unit.
// TESTING
//  MUL a=7 b=0xFFFF_FFFD -> valid @ accept+34, result=0xFFFF_FFEB; stall_req_o high cycles 0..33.
//  MULH a=b=0x8000_0000 -> 0x4000_0000. MULHU a=b=0xFFFF_FFFF -> 0xFFFF_FFFE.
//  MULHSU a=0xFFFF_FFFF b=2 -> 0xFFFF_FFFF.
//  DIV a=0xFFFF_FFF9(-7) b=2 -> 0xFFFF_FFFD. REM same -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU -> 2.
//  DIVU 5/0 -> 0xFFFF_FFFF and REMU 5/0 -> 5. DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000, REM -> 0.
//    All valid 1 cycle after accept.
//  flush_i at accept+10 -> IDLE, no valid pulse, stall_req_o low; next start gives correct result at +34.
//  rst_n low at accept+5 -> outputs 0 immediately; flush and start same cycle -> no accept.
//  Rerun MUL vectors with MDU_FAST_MUL_EN -> valid 1 cycle after accept.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 op encodings, FSM states
// and small op-classification helpers.
package muldiv_unit_pkg;

  localparam int MDU_OP_WIDTH = 3;

  typedef enum logic [MDU_OP_WIDTH-1:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  function automatic logic op_is_div(input mdu_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input mdu_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic a_is_signed(input mdu_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_is_signed(input mdu_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per step_i.
// The controlling FSM and sign fix-up live in muldiv_unit.
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Partial remainder stays below the divisor, so the top bit of diff is a clean borrow flag.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage; requests a pipeline stall while
// an M-op is in flight. Define MDU_FAST_MUL_EN for single-cycle multiplies (divides unchanged).
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [MDU_OP_WIDTH-1:0] op_i,
  input  logic [XLEN-1:0]         a_i,
  input  logic [XLEN-1:0]         b_i,
  input  logic [4:0]              rd_addr_i,
  input  logic                    flush_i,
  output logic                    stall_req_o,
  output logic                    result_valid_o,
  output logic [XLEN-1:0]         result_o,
  output logic [4:0]              rd_addr_o
);

  localparam int CW = $clog2(XLEN) + 1;

  // Handshake: start_i is a level held by EX while stall_req_o is high; an op is accepted on
  // the edge ending an IDLE cycle with start_i && !flush_i, and result_valid_o pulses once in DONE.

  mdu_state_t state, state_nxt;

  mdu_op_t           op_in, op_q;
  logic              a_neg_in, b_neg_in, a_neg_q, b_neg_q;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic              div_by_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              accept, last_step;
  logic              mul_step, div_step, div_load;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] prod, mcand, prod_s;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   quo, rem, quo_s, rem_s;
  logic              res_neg;
  logic [XLEN-1:0]   fix_res;

  assign op_in    = mdu_op_t'(op_i);
  assign a_neg_in = a_is_signed(op_in) & a_i[XLEN-1];
  assign b_neg_in = b_is_signed(op_in) & b_i[XLEN-1];
  assign a_mag_in = a_neg_in ? -a_i : a_i;
  assign b_mag_in = b_neg_in ? -b_i : b_i;

  // RISC-V defines these divide corner cases without trapping; they finish in one cycle.
  assign div_by_zero = op_is_div(op_in) && (b_i == '0);
  assign div_ovf     = (op_in inside {OP_DIV, OP_REM}) &&
                       (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
  assign special     = div_by_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_by_zero) special_res = op_is_rem(op_in) ? a_i : '1;
    else if (div_ovf) special_res = op_is_rem(op_in) ? '0 : a_i;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
  logic [XLEN-1:0]   fast_res;
  assign a_ext     = {{XLEN{a_neg_in}}, a_i};
  assign b_ext     = {{XLEN{b_neg_in}}, b_i};
  assign fast_prod = a_ext * b_ext;
  assign fast_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  assign accept    = (state == ST_IDLE) && start_i && !flush_i;
  assign last_step = (count == CW'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (special)               state_nxt = ST_DONE;
          else if (op_is_div(op_in)) state_nxt = ST_DIV;
          else begin
`ifdef MDU_FAST_MUL_EN
            state_nxt = ST_DONE;
`else
            state_nxt = ST_MUL;
`endif
          end
        end
      end
      ST_MUL:  if (last_step) state_nxt = ST_FIX;
      ST_DIV:  if (last_step) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush_i) state_nxt = ST_IDLE;
  end

  always_comb begin
    stall_req_o    = rst_n && (accept || (state inside {ST_MUL, ST_DIV, ST_FIX}));
    result_valid_o = (state == ST_DONE);
    mul_step       = (state == ST_MUL);
    div_step       = (state == ST_DIV);
    div_load       = accept && op_is_div(op_in) && !special;
  end

  mdu_div_core #(.XLEN(XLEN)) u_div_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (a_mag_in),
    .divisor_i   (b_mag_in),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  // Sign fix-up: product and quotient negate when operand signs differ; remainder follows dividend.
  assign res_neg = a_neg_q ^ b_neg_q;
  assign prod_s  = res_neg ? -prod : prod;
  assign quo_s   = res_neg ? -quo : quo;
  assign rem_s   = a_neg_q ? -rem : rem;

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_s;
      OP_REM, OP_REMU:              fix_res = rem_s;
      default:                      fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MUL;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      count     <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else if (accept) begin
      op_q      <= op_in;
      a_neg_q   <= a_neg_in;
      b_neg_q   <= b_neg_in;
      rd_addr_o <= rd_addr_i;
      count     <= '0;
      prod      <= '0;
      mcand     <= {{XLEN{1'b0}}, a_mag_in};
      mplier    <= b_mag_in;
      if (special) result_o <= special_res;
`ifdef MDU_FAST_MUL_EN
      else if (!op_is_div(op_in)) result_o <= fast_res;
`endif
    end else if (mul_step) begin
      count  <= count + CW'(1);
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (div_step) begin
      count <= count + CW'(1);
    end else if (state == ST_FIX) begin
      result_o <= fix_res;
    end
  end

endmodule
